// File: rtl/ad9122_spi_master.sv
// ad9122_spi_master
//   Turns one 16-bit AD9122 register command into a 4-wire SPI frame
//   (CSB, SCLK, SDIO out, SDO in) and reports completion with a one-cycle
//   CONFIG_END once the frame and the inter-frame CSB-high gap are finished.
//   Command word: [15] R/W (1 = read), [14:8] register address, [7:0] write data.
//
// Handshake: a request is a rising edge of CONFIG_EN seen while the FSM is
//   IDLE; CONFIG_DATA is captured in that same cycle. The matching response
//   is the single-cycle CONFIG_END pulse (RD_DATA valid alongside it for
//   read frames). BUSY covers the cycle after accept through the CONFIG_END
//   cycle; any rising edge inside that window is dropped and flagged on
//   DROP_ERR (sticky until reset). Holding CONFIG_EN high never retriggers.
//
// Ports
//   CLK, RST      system clock, asynchronous active-high reset
//   CONFIG_EN     command request (rising edge)
//   CONFIG_DATA   16-bit command word
//   CONFIG_END    one-cycle frame-complete pulse
//   RD_DATA       readback byte, updated with CONFIG_END of read frames
//   BUSY          frame in progress
//   DROP_ERR      sticky: request edge arrived while busy
//   SPI_CSB/SCLK/SDIO  DAC serial outputs (SCLK idles low, MSB first)
//   SPI_SDO       DAC serial readback input
//   dbg_state     current FSM state, for observation only
module ad9122_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CONFIG_EN,
  input  logic [15:0] CONFIG_DATA,
  output logic        CONFIG_END,
  output logic [7:0]  RD_DATA,
  output logic        BUSY,
  output logic        DROP_ERR,
  output logic        SPI_CSB,
  output logic        SPI_SCLK,
  output logic        SPI_SDIO,
  input  logic        SPI_SDO,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Counters compare against "last cycle" values so each phase lasts
  // exactly its parameter in CLK cycles.
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] sh_q, sh_d;
  logic        is_read_q, is_read_d;
  logic [7:0]  rx_q, rx_d;
  logic        csb_q, csb_d;
  logic        sclk_q, sclk_d;
  logic        sdio_q, sdio_d;
  logic        end_q, end_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        drop_q, drop_d;
  logic        en_q;
  logic        en_rise;

  assign en_rise = CONFIG_EN & ~en_q;

  // All pin-facing outputs are registers, so reset forces CSB high and
  // SCLK low in the same cycle it is asserted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      is_read_q <= 1'b0;
      rx_q      <= '0;
      csb_q     <= 1'b1;
      sclk_q    <= 1'b0;
      sdio_q    <= 1'b0;
      end_q     <= 1'b0;
      rd_data_q <= '0;
      drop_q    <= 1'b0;
      // Starts at 1 so an enable already high when reset releases is not an edge.
      en_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      is_read_q <= is_read_d;
      rx_q      <= rx_d;
      csb_q     <= csb_d;
      sclk_q    <= sclk_d;
      sdio_q    <= sdio_d;
      end_q     <= end_d;
      rd_data_q <= rd_data_d;
      drop_q    <= drop_d;
      en_q      <= CONFIG_EN;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    is_read_d = is_read_q;
    rx_d      = rx_q;
    csb_d     = csb_q;
    sclk_d    = sclk_q;
    sdio_d    = sdio_q;
    end_d     = 1'b0;
    rd_data_d = rd_data_q;
    drop_d    = drop_q;

    if (en_rise && (state_q != IDLE)) drop_d = 1'b1;

    case (state_q)
      IDLE: begin
        csb_d  = 1'b1;
        sclk_d = 1'b0;
        sdio_d = 1'b0;
        if (en_rise) begin
          state_d   = SETUP;
          sh_d      = CONFIG_DATA;
          is_read_d = CONFIG_DATA[15];
          rx_d      = '0;
          cnt_d     = '0;
          bit_d     = 4'd15;
          csb_d     = 1'b0;
          sdio_d    = CONFIG_DATA[15];
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SHIFT: begin
        // sclk_q doubles as the half-bit phase: low half first, then high.
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (is_read_q && (bit_q < 4'd8)) rx_d = {rx_q[6:0], SPI_SDO};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              state_d = HOLD;
              sdio_d  = 1'b0;
            end else begin
              bit_d = bit_q - 4'd1;
              sh_d  = {sh_q[14:0], 1'b0};
              // Data byte of a read frame is driven as zeros.
              sdio_d = (is_read_q && (bit_q <= 4'd8)) ? 1'b0 : sh_q[14];
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = GAP;
          csb_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == IDLE_LAST) begin
          state_d = DONE;
          end_d   = 1'b1;
          if (is_read_q) rd_data_d = rx_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign CONFIG_END = end_q;
  assign RD_DATA    = rd_data_q;
  assign BUSY       = (state_q != IDLE);
  assign DROP_ERR   = drop_q;
  assign SPI_CSB    = csb_q;
  assign SPI_SCLK   = sclk_q;
  assign SPI_SDIO   = sdio_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ad9122_spi_master.sv
// tb_ad9122_spi_master
//   Bench for ad9122_spi_master. Instance a uses default timing, instance b
//   the fastest legal timing. Expected frames are queued when issued and
//   checked by monitors that watch the SPI pins and CONFIG_END.
module tb_ad9122_spi_master;

  localparam int A_DIV = 4, A_SU = 2, A_HO = 2, A_ID = 4;
  localparam int A_LOW = A_SU + 32 * A_DIV + A_HO;
  localparam int A_LAT = A_LOW + A_ID + 1;
  localparam int B_DIV = 2, B_SU = 1, B_HO = 1, B_ID = 1;
  localparam int B_LOW = B_SU + 32 * B_DIV + B_HO;
  localparam int B_LAT = B_LOW + B_ID + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic        en_a, end_a, busy_a, drop_a, csb_a, sclk_a, sdio_a, sdo_a;
  logic [15:0] data_a;
  logic [7:0]  rd_a;
  logic [2:0]  st_a;
  logic        en_b, end_b, busy_b, drop_b, csb_b, sclk_b, sdio_b;
  logic [15:0] data_b;
  logic [7:0]  rd_b;
  logic [2:0]  st_b;
  logic        sdo_b = 1'b0;

  ad9122_spi_master #(.CLK_DIV(A_DIV), .CS_SETUP(A_SU), .CS_HOLD(A_HO), .CS_IDLE(A_ID)) dut_a (
    .CLK(clk), .RST(rst), .CONFIG_EN(en_a), .CONFIG_DATA(data_a),
    .CONFIG_END(end_a), .RD_DATA(rd_a), .BUSY(busy_a), .DROP_ERR(drop_a),
    .SPI_CSB(csb_a), .SPI_SCLK(sclk_a), .SPI_SDIO(sdio_a), .SPI_SDO(sdo_a),
    .dbg_state(st_a)
  );

  ad9122_spi_master #(.CLK_DIV(B_DIV), .CS_SETUP(B_SU), .CS_HOLD(B_HO), .CS_IDLE(B_ID)) dut_b (
    .CLK(clk), .RST(rst), .CONFIG_EN(en_b), .CONFIG_DATA(data_b),
    .CONFIG_END(end_b), .RD_DATA(rd_b), .BUSY(busy_b), .DROP_ERR(drop_b),
    .SPI_CSB(csb_b), .SPI_SCLK(sclk_b), .SPI_SDIO(sdio_b), .SPI_SDO(sdo_b),
    .dbg_state(st_b)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  // a entries: {accept cycle[31:0], SDIO word[15:0], RD_DATA at END[7:0]}
  logic [55:0] exp_a_q[$];
  // b entries: {accept cycle[31:0], SDIO word[15:0]}
  logic [47:0] exp_b_q[$];
  logic [7:0]  rd_model_a;
  logic        drop_model_a;
  logic [7:0]  resp_a;
  int          pushed_a = 0, ends_a = 0;
  logic [15:0] t3_cmds [3] = '{16'h0020, 16'h0000, 16'h1048};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // What the DAC must see on SDIO: full command for writes, data byte zero for reads.
  function automatic logic [15:0] sdio_word(input logic [15:0] cmd);
    return cmd[15] ? {cmd[15:8], 8'h00} : cmd;
  endfunction

  // ---------------- monitor a: SPI pins, SDO model, END ----------------
  logic        csb_p_a, sclk_p_a, sdio_p_a, end_p_a, seen_a;
  int          low_a, gap_a, hi_a, nbits_a, rises_a;
  logic [15:0] cap_a, word_a;
  logic [55:0] e_a;

  always @(negedge clk) begin
    if (rst) begin
      csb_p_a = 1'b1; sclk_p_a = 1'b0; sdio_p_a = 1'b0; end_p_a = 1'b0; seen_a = 1'b0;
      low_a = 0; gap_a = 0; hi_a = 0; nbits_a = 0; rises_a = 0;
      cap_a = '0; word_a = '0; sdo_a = 1'b0;
    end else begin
      if (!csb_a && csb_p_a) begin
        if (seen_a) check("csb_gap_a", 32'(gap_a >= A_ID + 2), 32'd1);
        low_a = 0; nbits_a = 0; rises_a = 0; cap_a = '0;
        sdo_a = 1'($urandom);
      end
      if (csb_a && !csb_p_a) begin
        check("csb_low_a", 32'(low_a), 32'(A_LOW));
        check("bit_count_a", 32'(nbits_a), 32'd16);
        word_a = cap_a; seen_a = 1'b1; gap_a = 0;
      end
      if (!csb_a) low_a++; else gap_a++;

      if (sclk_a && !sclk_p_a) begin
        cap_a = {cap_a[14:0], sdio_a};
        nbits_a++; rises_a++; hi_a = 1;
        // Present the readback bit for the next rise; only bits 7..0 matter.
        if (rises_a >= 8 && rises_a <= 15) sdo_a = resp_a[15 - rises_a];
        else sdo_a = 1'($urandom);
      end else if (sclk_a && sclk_p_a) begin
        hi_a++;
        check("sdio_stable_a", 32'(sdio_a), 32'(sdio_p_a));
      end else if (!sclk_a && sclk_p_a) begin
        check("sclk_high_a", 32'(hi_a), 32'(A_DIV));
      end

      if (end_a) begin
        ends_a++;
        check("end_width_a", 32'(end_p_a), 32'd0);
        if (exp_a_q.size() == 0) begin
          check("end_unexpected_a", 32'd1, 32'd0);
        end else begin
          e_a = exp_a_q.pop_front();
          check("end_latency_a", 32'(cyc) - e_a[55:24], 32'(A_LAT));
          check("sdio_word_a", 32'(word_a), 32'(e_a[23:8]));
          check("rd_data_a", 32'(rd_a), 32'(e_a[7:0]));
          check("busy_at_end_a", 32'(busy_a), 32'd1);
        end
      end
      csb_p_a = csb_a; sclk_p_a = sclk_a; sdio_p_a = sdio_a; end_p_a = end_a;
    end
  end

  // ---------------- monitor b ----------------
  logic        csb_p_b, sclk_p_b;
  int          low_b, hi_b, nbits_b;
  logic [15:0] cap_b, word_b;
  logic [47:0] e_b;

  always @(negedge clk) begin
    if (rst) begin
      csb_p_b = 1'b1; sclk_p_b = 1'b0; low_b = 0; hi_b = 0; nbits_b = 0;
      cap_b = '0; word_b = '0;
    end else begin
      if (!csb_b && csb_p_b) begin low_b = 0; nbits_b = 0; cap_b = '0; end
      if (csb_b && !csb_p_b) begin
        check("csb_low_b", 32'(low_b), 32'(B_LOW));
        check("bit_count_b", 32'(nbits_b), 32'd16);
        word_b = cap_b;
      end
      if (!csb_b) low_b++;
      if (sclk_b && !sclk_p_b) begin
        cap_b = {cap_b[14:0], sdio_b}; nbits_b++; hi_b = 1;
      end else if (sclk_b && sclk_p_b) begin
        hi_b++;
      end else if (!sclk_b && sclk_p_b) begin
        check("sclk_high_b", 32'(hi_b), 32'(B_DIV));
      end
      if (end_b) begin
        if (exp_b_q.size() == 0) begin
          check("end_unexpected_b", 32'd1, 32'd0);
        end else begin
          e_b = exp_b_q.pop_front();
          check("end_latency_b", 32'(cyc) - e_b[47:16], 32'(B_LAT));
          check("sdio_word_b", 32'(word_b), 32'(e_b[15:0]));
          check("rd_data_b", 32'(rd_b), 32'd0);
        end
      end
      csb_p_b = csb_b; sclk_p_b = sclk_b;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_a(input logic [15:0] cmd, input logic [7:0] resp);
    exp_a_q.push_back({32'(cyc), sdio_word(cmd), cmd[15] ? resp : rd_model_a});
    if (cmd[15]) rd_model_a = resp;
    pushed_a++;
  endtask

  task automatic wait_idle_a();
    int t = 0;
    while (busy_a && t < 1000) begin tick(); t++; end
    if (busy_a) check("idle_timeout_a", 32'd1, 32'd0);
  endtask

  task automatic wait_end_a();
    int t = 0;
    tick();
    while (!end_a && t < 2000) begin tick(); t++; end
    if (!end_a) check("end_timeout_a", 32'd1, 32'd0);
  endtask

  // Rising edge on EN held for 'hold' cycles; data scrambled after accept.
  task automatic pulse_a(input logic [15:0] cmd, input logic [7:0] resp, input int hold);
    wait_idle_a();
    data_a = cmd; resp_a = resp; en_a = 1'b1;
    push_a(cmd, resp);
    tick();
    data_a = 16'($urandom);
    repeat (hold - 1) tick();
    en_a = 1'b0;
    tick();
  endtask

  task automatic pulse_b(input logic [15:0] cmd);
    int t = 0;
    while (busy_b && t < 1000) begin tick(); t++; end
    if (busy_b) check("idle_timeout_b", 32'd1, 32'd0);
    data_b = cmd; en_b = 1'b1;
    exp_b_q.push_back({32'(cyc), sdio_word(cmd)});
    tick();
    data_b = 16'($urandom); en_b = 1'b0;
    t = 0;
    while (!end_b && t < 1000) begin tick(); t++; end
    if (!end_b) check("end_timeout_b", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    rd_model_a = '0; drop_model_a = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; data_a = '0; data_b = '0;
    resp_a = '0; rd_model_a = '0; drop_model_a = 1'b0;
    repeat (3) tick();
    check("rst_csb_a", 32'(csb_a), 32'd1);
    check("rst_sclk_a", 32'(sclk_a), 32'd0);
    check("rst_sdio_a", 32'(sdio_a), 32'd0);
    check("rst_end_a", 32'(end_a), 32'd0);
    check("rst_rd_a", 32'(rd_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_drop_a", 32'(drop_a), 32'd0);
    check("rst_csb_b", 32'(csb_b), 32'd1);
    rst = 1'b0;
    repeat (2) tick();

    // Single write, then single read with DAC answering A5.
    pulse_a(16'h1048, 8'h00, 1);
    wait_end_a();
    pulse_a(16'h9F00, 8'hA5, 1);
    wait_end_a();

    // Sequencer style: EN high through the frame, low one cycle after END.
    tick();
    for (int i = 0; i < 3; i++) begin
      data_a = t3_cmds[i]; en_a = 1'b1;
      push_a(t3_cmds[i], 8'h00);
      wait_end_a();
      tick();
      en_a = 1'b0;
      tick();
    end
    check("drop_after_seq", 32'(drop_a), 32'(drop_model_a));

    // Random commands, random gaps, random EN hold lengths.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 5)) tick();
      pulse_a(16'($urandom), 8'($urandom), int'($urandom_range(1, 200)));
    end
    wait_idle_a();
    tick();
    check("drop_after_random", 32'(drop_a), 32'(drop_model_a));

    // EN 1->0->1 at the fifth SCLK rise: dropped, frame unaffected.
    data_a = 16'h2A5C; en_a = 1'b1;
    push_a(16'h2A5C, 8'h00);
    repeat (38) tick();
    en_a = 1'b0;
    tick();
    en_a = 1'b1; drop_model_a = 1'b1;
    wait_end_a();
    tick();
    en_a = 1'b0;
    tick();
    check("drop_mid_frame", 32'(drop_a), 32'(drop_model_a));

    // Edge in the CONFIG_END cycle is dropped and never starts a frame.
    do_reset();
    check("drop_cleared", 32'(drop_a), 32'(drop_model_a));
    pulse_a(16'h0155, 8'h00, 1);
    wait_end_a();
    en_a = 1'b1; drop_model_a = 1'b1;
    repeat (10) begin
      tick();
      check("no_frame_after_end_edge", 32'(csb_a), 32'd1);
    end
    check("drop_end_cycle", 32'(drop_a), 32'(drop_model_a));
    en_a = 1'b0;
    tick();
    pulse_a(16'h8133, 8'h3C, 1);
    wait_end_a();
    tick();

    // Reset during bit 8 (SCLK high), EN held high across reset.
    wait_idle_a();
    data_a = 16'h9E77; en_a = 1'b1;
    repeat (64) tick();
    rst = 1'b1;
    #1;
    check("abort_csb", 32'(csb_a), 32'd1);
    check("abort_sclk", 32'(sclk_a), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    rd_model_a = '0; drop_model_a = 1'b0;
    repeat (20) begin
      tick();
      check("held_en_no_frame", 32'(csb_a), 32'd1);
    end
    check("held_en_rd", 32'(rd_a), 32'(rd_model_a));
    en_a = 1'b0;
    tick();
    pulse_a(16'h1048, 8'h00, 1);
    wait_end_a();
    tick();

    // Minimum timing instance.
    pulse_b(16'h4503);
    for (int i = 0; i < 4; i++) begin
      tick();
      pulse_b(16'($urandom));
    end
    repeat (5) tick();

    check("queue_a_empty", 32'(exp_a_q.size()), 32'd0);
    check("queue_b_empty", 32'(exp_b_q.size()), 32'd0);
    check("ends_vs_frames_a", 32'(ends_a), 32'(pushed_a));
    check("drop_final", 32'(drop_a), 32'(drop_model_a));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
